// File: rtl/boid_pixel_writer_if.sv
`default_nettype none
`timescale 1ns/1ps
// boid_pixel_writer_if: coordinate handshake plus framebuffer write port.
// Rev 1.0 - initial release
interface boid_pixel_writer_if;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  x_loc;
  logic [8:0]  y_loc;
  logic        wr_en;
  logic [19:0] wr_addr;
  logic [8:0]  wr_data;
  logic        busy;
  logic        drop;

  modport master (
    output in_valid, x_loc, y_loc,
    input  in_ready, wr_en, wr_addr, wr_data, busy, drop
  );

  modport slave (
    input  in_valid, x_loc, y_loc,
    output in_ready, wr_en, wr_addr, wr_data, busy, drop
  );
endinterface
`default_nettype wire

// File: rtl/boid_pixel_writer.sv
`default_nettype none
`timescale 1ns/1ps
// boid_pixel_writer: erases a boid's previous pixel and draws its new one (640-wide framebuffer).
// Optional macro BOID_BOUNDS_CHECK_EN drops off-screen coordinates. Rev 1.0 - initial release
module boid_pixel_writer #(
  parameter logic [8:0] BOID_COLOR = 9'h0FF,
  parameter logic [8:0] BG_COLOR   = 9'h000
) (
  input  wire logic          clock,
  input  wire logic          reset,
  boid_pixel_writer_if.slave bif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ERASE = 2'd2,
    S_DRAW  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic [19:0] r_new_addr;
  logic [19:0] r_prev_addr;
  logic        r_have_prev;
  logic        r_wr_en;
  logic [19:0] r_wr_addr;
  logic [8:0]  r_wr_data;

  logic        w_accept;
  logic [19:0] w_new_addr;
  logic        w_oob;
  logic        w_wr_en_nxt;
  logic [19:0] w_wr_addr_nxt;
  logic [8:0]  w_wr_data_nxt;
  logic        w_load_prev;

  assign w_accept   = bif.in_valid && (r_state == S_IDLE);
  // 640*y as two shifts so no multiplier is inferred
  assign w_new_addr = 20'(r_x) + (20'(r_y) << 9) + (20'(r_y) << 7);

`ifdef BOID_BOUNDS_CHECK_EN
  logic r_drop;
  logic w_drop_nxt;
  assign w_oob    = (r_x >= 10'd640) || (r_y >= 9'd480);
  assign bif.drop = r_drop;
`else
  assign w_oob    = 1'b0;
  assign bif.drop = 1'b0;
`endif

  assign bif.in_ready = (r_state == S_IDLE);
  assign bif.busy     = (r_state != S_IDLE);
  assign bif.wr_en    = r_wr_en;
  assign bif.wr_addr  = r_wr_addr;
  assign bif.wr_data  = r_wr_data;

  // Write outputs are computed one state early so the registered strobe lines up with its state.
  always_comb begin
    w_state_nxt   = r_state;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_load_prev   = 1'b0;
`ifdef BOID_BOUNDS_CHECK_EN
    w_drop_nxt    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        if (w_oob) begin
          w_state_nxt = S_IDLE;
`ifdef BOID_BOUNDS_CHECK_EN
          w_drop_nxt  = 1'b1;
`endif
        end else begin
          w_state_nxt = S_ERASE;
          if (r_have_prev && (r_prev_addr != w_new_addr)) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = r_prev_addr;
            w_wr_data_nxt = BG_COLOR;
          end
        end
      end
      S_ERASE: begin
        w_state_nxt   = S_DRAW;
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = r_new_addr;
        w_wr_data_nxt = BOID_COLOR;
      end
      S_DRAW: begin
        w_state_nxt = S_IDLE;
        w_load_prev = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_new_addr  <= '0;
      r_prev_addr <= '0;
      r_have_prev <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      if (w_accept) begin
        r_x <= bif.x_loc;
        r_y <= bif.y_loc;
      end
      if (r_state == S_CALC) r_new_addr <= w_new_addr;
      if (w_load_prev) begin
        r_prev_addr <= r_new_addr;
        r_have_prev <= 1'b1;
      end
    end
  end

`ifdef BOID_BOUNDS_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_drop <= 1'b0;
    else       r_drop <= w_drop_nxt;
  end
`endif

endmodule
`default_nettype wire
